// File: rtl/char_pixel_serializer_pkg.sv
// char_pixel_serializer_pkg
// Shared BubSys character-pipeline constants and helpers.
// - FETCH_TM : i_EMU_TIMING value at which the char RAM word is captured
// - PIX_STEP : i_EMU_TIMING[2:0] value of the last MCLK of a pixel (pixel strobe)
// - TM_A/TM_B: tilemap select encodings
// - nib_rev  : reverse the eight nibbles of a graphics word (horizontal flip)
package char_pixel_serializer_pkg;

    localparam logic [4:0] FETCH_TM  = 5'b11000;
    localparam logic [2:0] PIX_STEP  = 3'd5;
    localparam logic       TM_A      = 1'b0;
    localparam logic       TM_B      = 1'b1;

    localparam int         NUM_LANES = 2;
    localparam int         VEC_W     = 32;
    localparam int         DLY_N     = 7;

    function automatic logic [VEC_W-1:0] nib_rev(input logic [VEC_W-1:0] w);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = w[(7-i)*4 +: 4];
        return r;
    endfunction

endpackage

// File: rtl/char_pixel_serializer_lane.sv
// char_pixel_lane
// One tilemap lane: hold register, 4bpp shifter, 7-stage fine-scroll delay
// line and output register.
// Ports:
//   i_EMU_MCLK, i_EMU_MRST_n : clock, synchronous active-low reset
//   stb                      : pixel strobe (one per 6 MCLK)
//   cap_en                   : write {gfx, attr, flipx} into the hold register
//   tile_load                : on stb, load shifter from hold instead of shifting
//   gfx, attr, flipx         : fetched tile word, palette code, flip-X
//   finescr                  : fine scroll, 0..7 pixels of delay
//   pix, pal, opaque         : registered pixel, palette, pix != 0
module char_pixel_lane
    import char_pixel_serializer_pkg::*;
#(
    parameter int PAL_W = 7
) (
    input  logic             i_EMU_MCLK,
    input  logic             i_EMU_MRST_n,
    input  logic             stb,
    input  logic             cap_en,
    input  logic             tile_load,
    input  logic [VEC_W-1:0] gfx,
    input  logic [PAL_W-1:0] attr,
    input  logic             flipx,
    input  logic [2:0]       finescr,
    output logic [3:0]       pix,
    output logic [PAL_W-1:0] pal,
    output logic             opaque
);

    typedef struct packed {
        logic [VEC_W-1:0] gfx;
        logic [PAL_W-1:0] attr;
        logic             flipx;
    } hold_t;

    hold_t                        hold;
    logic [VEC_W-1:0]             shft;
    logic [PAL_W-1:0]             pal_r;
    logic [DLY_N-1:0][3:0]        d_pix;
    logic [DLY_N-1:0][PAL_W-1:0]  d_pal;
    logic [3:0]                   head_pix;
    logic [3:0]                   sel_pix;
    logic [PAL_W-1:0]             sel_pal;

    // Head is the pre-strobe shifter top nibble, so a tile loaded on strobe n
    // shows pixel0 at the head on strobe n+1.
    assign head_pix = shft[VEC_W-1 -: 4];

    // Tap F selects D[F-1]; F == 0 bypasses the delay line.
    always_comb begin
        sel_pix = head_pix;
        sel_pal = pal_r;
        if (finescr != 3'd0) begin
            sel_pix = d_pix[finescr - 3'd1];
            sel_pal = d_pal[finescr - 3'd1];
        end
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_MRST_n) begin
            hold   <= '0;
            shft   <= '0;
            pal_r  <= '0;
            d_pix  <= '0;
            d_pal  <= '0;
            pix    <= '0;
            pal    <= '0;
            opaque <= 1'b0;
        end else begin
            if (cap_en) hold <= '{gfx: gfx, attr: attr, flipx: flipx};
            if (stb) begin
                if (tile_load) begin
                    shft  <= hold.flipx ? nib_rev(hold.gfx) : hold.gfx;
                    pal_r <= hold.attr;
                end else begin
                    shft  <= {shft[VEC_W-5:0], 4'h0};
                end
                d_pix  <= {d_pix[DLY_N-2:0], head_pix};
                d_pal  <= {d_pal[DLY_N-2:0], pal_r};
                pix    <= sel_pix;
                pal    <= sel_pal;
                opaque <= |sel_pix;
            end
        end
    end

endmodule

// File: rtl/char_pixel_serializer.sv
// char_pixel_serializer
// Latches TM-A / TM-B char RAM words on their fetch slots and serialises each
// into 4bpp pixels with per-tilemap flip-X and fine scroll.
// Ports:
//   i_EMU_MCLK, i_EMU_MRST_n : master clock, synchronous active-low reset
//   i_EMU_TIMING             : [4:3] pixel phase, [2:0] MCLK step in pixel
//   i_GFXDATA, i_ATTR, i_FLIPX, i_TMSEL : fetched tile and owning tilemap
//   i_TILE_LOAD              : tile boundary, used on the pixel strobe only
//   i_FINESCR_A/B            : fine scroll per tilemap
//   o_PIX_*, o_PAL_*, o_OPAQUE_* : per-tilemap pixel outputs to the mixer
module char_pixel_serializer
    import char_pixel_serializer_pkg::*;
#(
    parameter int PAL_W = 7
) (
    input  logic             i_EMU_MCLK,
    input  logic             i_EMU_MRST_n,
    input  logic [4:0]       i_EMU_TIMING,
    input  logic [31:0]      i_GFXDATA,
    input  logic             i_TMSEL,
    input  logic [PAL_W-1:0] i_ATTR,
    input  logic             i_FLIPX,
    input  logic             i_TILE_LOAD,
    input  logic [2:0]       i_FINESCR_A,
    input  logic [2:0]       i_FINESCR_B,
    output logic [3:0]       o_PIX_A,
    output logic [3:0]       o_PIX_B,
    output logic [PAL_W-1:0] o_PAL_A,
    output logic [PAL_W-1:0] o_PAL_B,
    output logic             o_OPAQUE_A,
    output logic             o_OPAQUE_B
);

    logic                              stb;
    logic                              fetch;
    logic [NUM_LANES-1:0]              cap_en;
    logic [NUM_LANES-1:0][2:0]         finescr;
    logic [NUM_LANES-1:0][3:0]         pix;
    logic [NUM_LANES-1:0][PAL_W-1:0]   pal;
    logic [NUM_LANES-1:0]              opaque;

    assign stb          = (i_EMU_TIMING[2:0] == PIX_STEP);
    assign fetch        = (i_EMU_TIMING == FETCH_TM);
    assign cap_en[TM_A] = fetch & (i_TMSEL == TM_A);
    assign cap_en[TM_B] = fetch & (i_TMSEL == TM_B);
    assign finescr      = {i_FINESCR_B, i_FINESCR_A};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        char_pixel_lane #(.PAL_W(PAL_W)) u_lane (
            .i_EMU_MCLK   (i_EMU_MCLK),
            .i_EMU_MRST_n (i_EMU_MRST_n),
            .stb          (stb),
            .cap_en       (cap_en[g]),
            .tile_load    (i_TILE_LOAD),
            .gfx          (i_GFXDATA),
            .attr         (i_ATTR),
            .flipx        (i_FLIPX),
            .finescr      (finescr[g]),
            .pix          (pix[g]),
            .pal          (pal[g]),
            .opaque       (opaque[g])
        );
    end

    assign o_PIX_A    = pix[TM_A];
    assign o_PIX_B    = pix[TM_B];
    assign o_PAL_A    = pal[TM_A];
    assign o_PAL_B    = pal[TM_B];
    assign o_OPAQUE_A = opaque[TM_A];
    assign o_OPAQUE_B = opaque[TM_B];

endmodule

// File: tb/tb_char_pixel_serializer.sv
// Self-checking bench for char_pixel_serializer: table of tile vectors with
// hand-written expected pixel streams, a per-strobe scoreboard queue, and
// hand sequences for reset behaviour.
module tb_char_pixel_serializer;

    localparam int PAL_W = 7;

    logic             i_EMU_MCLK = 1'b0;
    logic             i_EMU_MRST_n;
    logic [4:0]       i_EMU_TIMING;
    logic [31:0]      i_GFXDATA;
    logic             i_TMSEL;
    logic [PAL_W-1:0] i_ATTR;
    logic             i_FLIPX;
    logic             i_TILE_LOAD;
    logic [2:0]       i_FINESCR_A;
    logic [2:0]       i_FINESCR_B;
    logic [3:0]       o_PIX_A, o_PIX_B;
    logic [PAL_W-1:0] o_PAL_A, o_PAL_B;
    logic             o_OPAQUE_A, o_OPAQUE_B;

    always #5 i_EMU_MCLK = ~i_EMU_MCLK;

    char_pixel_serializer #(.PAL_W(PAL_W)) dut (
        .i_EMU_MCLK   (i_EMU_MCLK),
        .i_EMU_MRST_n (i_EMU_MRST_n),
        .i_EMU_TIMING (i_EMU_TIMING),
        .i_GFXDATA    (i_GFXDATA),
        .i_TMSEL      (i_TMSEL),
        .i_ATTR       (i_ATTR),
        .i_FLIPX      (i_FLIPX),
        .i_TILE_LOAD  (i_TILE_LOAD),
        .i_FINESCR_A  (i_FINESCR_A),
        .i_FINESCR_B  (i_FINESCR_B),
        .o_PIX_A      (o_PIX_A),
        .o_PIX_B      (o_PIX_B),
        .o_PAL_A      (o_PAL_A),
        .o_PAL_B      (o_PAL_B),
        .o_OPAQUE_A   (o_OPAQUE_A),
        .o_OPAQUE_B   (o_OPAQUE_B)
    );

    typedef struct {
        logic             cap_a;
        logic [31:0]      w_a;
        logic [PAL_W-1:0] at_a;
        logic             fl_a;
        logic             cap_b;
        logic [31:0]      w_b;
        logic [PAL_W-1:0] at_b;
        logic             fl_b;
        logic [2:0]       fa;
        logic [2:0]       fb;
        logic [31:0]      exp_a;   // expected pixel stream, pixel0 in [31:28]
        logic [PAL_W-1:0] epal_a;
        logic [31:0]      exp_b;
        logic [PAL_W-1:0] epal_b;
    } vec_t;

    typedef struct {
        logic [3:0]       pix_a;
        logic [PAL_W-1:0] pal_a;
        logic             chk_pal_a;
        logic [3:0]       pix_b;
        logic [PAL_W-1:0] pal_b;
        logic             chk_pal_b;
    } exp_t;

    vec_t tbl [5];
    exp_t sb_q [$];

    int n_checks  = 0;
    int n_fail    = 0;
    int strobe_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (strobe %0d): got %h, expected %h", name, strobe_no, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [31:0] s, input int k);
        if (k < 0 || k > 7) return 4'h0;
        return s[(7-k)*4 +: 4];
    endfunction

    function automatic logic [31:0] all_out();
        return {8'h0, o_PIX_A, o_PAL_A, o_OPAQUE_A, o_PIX_B, o_PAL_B, o_OPAQUE_B};
    endfunction

    task automatic mclk(input logic [4:0] t);
        i_EMU_TIMING = t;
        @(posedge i_EMU_MCLK);
        #1;
    endtask

    // One 6-MCLK pixel; phase 3 makes step 0 the fetch slot.
    task automatic pixel(input logic [1:0] ph, input logic ld);
        i_TILE_LOAD = ld;
        for (int s = 0; s < 6; s++) mclk({ph, 3'(s)});
        i_TILE_LOAD = 1'b0;
        strobe_no++;
    endtask

    task automatic capture(input logic sel, input logic [31:0] w,
                           input logic [PAL_W-1:0] at, input logic fl);
        i_TMSEL   = sel;
        i_GFXDATA = w;
        i_ATTR    = at;
        i_FLIPX   = fl;
        pixel(2'd3, 1'b0);
        i_GFXDATA = 32'hDEAD_BEEF;   // garbage outside the fetch slot
        i_ATTR    = 7'h55;
        i_FLIPX   = 1'b1;
    endtask

    initial begin
        vec_t v;
        exp_t e;
        exp_t got;
        int   ka;
        int   kb;

        tbl[0] = '{1'b1, 32'h12345678, 7'h15, 1'b0,  1'b0, 32'h0, 7'h00, 1'b0,
                   3'd0, 3'd0, 32'h12345678, 7'h15, 32'h00000000, 7'h00};
        tbl[1] = '{1'b0, 32'h0, 7'h00, 1'b0,  1'b1, 32'h12345678, 7'h2A, 1'b1,
                   3'd0, 3'd3, 32'h12345678, 7'h15, 32'h87654321, 7'h2A};
        tbl[2] = '{1'b1, 32'h0F0F0F0F, 7'h01, 1'b0,  1'b0, 32'h0, 7'h00, 1'b0,
                   3'd2, 3'd0, 32'h0F0F0F0F, 7'h01, 32'h87654321, 7'h2A};
        tbl[3] = '{1'b0, 32'h0, 7'h00, 1'b0,  1'b0, 32'h0, 7'h00, 1'b0,
                   3'd2, 3'd5, 32'h0F0F0F0F, 7'h01, 32'h87654321, 7'h2A};
        tbl[4] = '{1'b1, 32'hCAFEBABE, 7'h7F, 1'b1,  1'b1, 32'h9ABCDEF0, 7'h33, 1'b0,
                   3'd1, 3'd7, 32'hEBABEFAC, 7'h7F, 32'h9ABCDEF0, 7'h33};

        i_EMU_MRST_n = 1'b0;
        i_EMU_TIMING = 5'd0;
        i_GFXDATA    = 32'hFFFF_FFFF;
        i_TMSEL      = 1'b0;
        i_ATTR       = 7'h7F;
        i_FLIPX      = 1'b0;
        i_TILE_LOAD  = 1'b0;
        i_FINESCR_A  = 3'd0;
        i_FINESCR_B  = 3'd0;
        repeat (3) mclk(5'd0);
        check("reset_outputs", all_out(), 32'h0);
        i_EMU_MRST_n = 1'b1;

        for (int p = 0; p < 8; p++) begin
            pixel(2'd1, 1'b0);
            check("idle_no_load", all_out(), 32'h0);
        end

        for (int r = 0; r < 5; r++) begin
            v = tbl[r];
            i_FINESCR_A = v.fa;
            i_FINESCR_B = v.fb;
            if (v.cap_a) capture(1'b0, v.w_a, v.at_a, v.fl_a);
            if (v.cap_b) capture(1'b1, v.w_b, v.at_b, v.fl_b);
            pixel(2'd1, 1'b1);
            for (int j = 1; j <= 16; j++) begin
                ka = j - 1 - int'(v.fa);
                kb = j - 1 - int'(v.fb);
                e.pix_a     = nib(v.exp_a, ka);
                e.pal_a     = v.epal_a;
                e.chk_pal_a = (ka >= 0 && ka < 8);
                e.pix_b     = nib(v.exp_b, kb);
                e.pal_b     = v.epal_b;
                e.chk_pal_b = (kb >= 0 && kb < 8);
                sb_q.push_back(e);
                pixel(2'd1, 1'b0);
                got = sb_q.pop_front();
                check($sformatf("vec%0d pix_a", r), 32'(o_PIX_A), 32'(got.pix_a));
                check($sformatf("vec%0d opaque_a", r), 32'(o_OPAQUE_A), 32'(got.pix_a != 4'h0));
                check($sformatf("vec%0d pix_b", r), 32'(o_PIX_B), 32'(got.pix_b));
                check($sformatf("vec%0d opaque_b", r), 32'(o_OPAQUE_B), 32'(got.pix_b != 4'h0));
                if (got.chk_pal_a) check($sformatf("vec%0d pal_a", r), 32'(o_PAL_A), 32'(got.pal_a));
                if (got.chk_pal_b) check($sformatf("vec%0d pal_b", r), 32'(o_PAL_B), 32'(got.pal_b));
            end
        end

        // Reset for one MCLK in the middle of a tile.
        i_FINESCR_A = 3'd0;
        i_FINESCR_B = 3'd0;
        capture(1'b0, 32'h12345678, 7'h15, 1'b0);
        pixel(2'd1, 1'b1);
        repeat (4) pixel(2'd1, 1'b0);
        check("midtile_pre_reset_pix_a", 32'(o_PIX_A), 32'h4);
        for (int s = 0; s < 3; s++) mclk({2'd1, 3'(s)});
        i_EMU_MRST_n = 1'b0;
        mclk({2'd1, 3'd3});
        check("midtile_reset_outputs", all_out(), 32'h0);
        i_EMU_MRST_n = 1'b1;
        mclk({2'd1, 3'd4});
        mclk({2'd1, 3'd5});
        strobe_no++;
        check("post_reset_strobe", all_out(), 32'h0);
        pixel(2'd1, 1'b1);
        for (int p = 0; p < 10; p++) begin
            pixel(2'd1, 1'b0);
            check("post_reset_zero_hold_load", all_out(), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
